// File: rtl/iddr_chk_pkg.sv
// rtl/iddr_chk_pkg.sv - shared state type and parameter defaults for the IDDR pair checker
package iddr_chk_pkg;

  typedef enum logic [1:0] {
    LEARN  = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam int DEF_WORD_W     = 8;
  localparam int DEF_LOCK_COUNT = 16;
  localparam int DEF_MAX_MISS   = 4;
  localparam int DEF_ERR_CNT_W  = 16;

endpackage

// File: rtl/iddr_pair_deser.sv
// rtl/iddr_pair_deser.sv - registers IDDR Q1/Q2 pairs and assembles them into words, MSB first
// Pair order is {q2,q1} when IDDR_PAIR_CHECKER_SWAP_EN is defined, {q1,q2} otherwise.
module iddr_pair_deser
  import iddr_chk_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q1,
  input  logic              q2,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid
);

  localparam int PAIRS = WORD_W / 2;
  localparam int PC_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  logic              q1_q, q2_q, in_vld_q;
  logic [1:0]        pair;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [PC_W-1:0]   pair_cnt_q, pair_cnt_d;
  logic [WORD_W-1:0] word_q;
  logic              word_valid_q;
  logic              wrap;

`ifdef IDDR_PAIR_CHECKER_SWAP_EN
  assign pair = {q2_q, q1_q};
`else
  assign pair = {q1_q, q2_q};
`endif

  // in_vld_q keeps the reset value of the input stage out of the first word.
  always_comb begin
    sr_d       = {sr_q[WORD_W-3:0], pair};
    wrap       = in_vld_q && (pair_cnt_q == PC_W'(PAIRS - 1));
    pair_cnt_d = pair_cnt_q;
    if (in_vld_q) begin
      pair_cnt_d = wrap ? '0 : pair_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1_q         <= 1'b0;
      q2_q         <= 1'b0;
      in_vld_q     <= 1'b0;
      sr_q         <= '0;
      pair_cnt_q   <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      q1_q         <= q1;
      q2_q         <= q2;
      in_vld_q     <= 1'b1;
      sr_q         <= sr_d;
      pair_cnt_q   <= pair_cnt_d;
      word_valid_q <= wrap;
      if (wrap) begin
        word_q <= sr_d;
      end
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: rtl/iddr_pair_checker.sv
// rtl/iddr_pair_checker.sv - learns a reference word, locks on repeats, counts mismatches while locked
// Build option IDDR_PAIR_CHECKER_SWAP_EN swaps the Q1/Q2 pair order in the deserializer.
module iddr_pair_checker
  import iddr_chk_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int MAX_MISS   = DEF_MAX_MISS,
  parameter int ERR_CNT_W  = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 q1,
  input  logic                 q2,
  input  logic                 clr,
  output logic [WORD_W-1:0]    word_out,
  output logic                 word_valid,
  output logic                 locked,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int MM_W = $clog2(MAX_MISS + 1);

  chk_state_t           state_q, state_d;
  logic [WORD_W-1:0]    ref_q, ref_d;
  logic [MC_W-1:0]      match_cnt_q, match_cnt_d;
  logic [MM_W-1:0]      miss_cnt_q, miss_cnt_d;
  logic                 locked_q, locked_d;
  logic                 err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 hit;

  iddr_pair_deser #(.WORD_W(WORD_W)) u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .q1         (q1),
    .q2         (q2),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  assign hit = (word_out == ref_q);

  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (word_valid) begin
      case (state_q)
        LEARN: begin
          ref_d       = word_out;
          match_cnt_d = '0;
          state_d     = CHECK;
        end
        CHECK: begin
          if (hit) begin
            match_cnt_d = match_cnt_q + 1'b1;
            if (match_cnt_d == MC_W'(LOCK_COUNT)) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
            end
          end else begin
            ref_d       = word_out;
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            miss_cnt_d = '0;
          end else begin
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            err_flag_d = 1'b1;
            miss_cnt_d = miss_cnt_q + 1'b1;
            // The mismatch that triggers relearn is still counted above.
            if (miss_cnt_d == MM_W'(MAX_MISS)) begin
              state_d     = LEARN;
              locked_d    = 1'b0;
              miss_cnt_d  = '0;
              match_cnt_d = '0;
            end
          end
        end
        default: state_d = LEARN;
      endcase
    end
    if (clr) begin
      err_count_d = '0;
      err_flag_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LEARN;
      ref_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_iddr_pair_checker.sv
// tb/tb_iddr_pair_checker.sv - scoreboard bench for iddr_pair_checker (WORD_W=8, LOCK_COUNT=4, MAX_MISS=2, ERR_CNT_W=2)
module tb_iddr_pair_checker;

  localparam int WW = 8;
  localparam int LC = 4;
  localparam int MM = 2;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          q1 = 1'b0;
  logic          q2 = 1'b0;
  logic          clr = 1'b0;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          locked;
  logic          err_flag;
  logic [EW-1:0] err_count;

  iddr_pair_checker #(
    .WORD_W(WW), .LOCK_COUNT(LC), .MAX_MISS(MM), .ERR_CNT_W(EW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q1         (q1),
    .q2         (q2),
    .clr        (clr),
    .word_out   (word_out),
    .word_valid (word_valid),
    .locked     (locked),
    .err_flag   (err_flag),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] word;
    logic       lk;
    logic       fl;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  bit   clr_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;
  bit   first_seen = 0;
  bit   pend = 0;
  exp_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_word(input logic [7:0] p);
    logic [7:0] r;
`ifdef IDDR_PAIR_CHECKER_SWAP_EN
    for (int i = 0; i < 4; i++) begin
      r[2*i+1] = p[2*i];
      r[2*i]   = p[2*i+1];
    end
`else
    r = p;
`endif
    return r;
  endfunction

  // Drives one word as four {q1,q2} pairs, MSB pair first, and queues the expected result.
  task automatic w(input logic [7:0] p, input logic lk, input logic fl, input logic [1:0] cnt, input bit c);
    exp_q.push_back('{exp_word(p), lk, fl, cnt});
    clr_q.push_back(c);
    for (int i = 3; i >= 0; i--) begin
      q1 = p[2*i+1];
      q2 = p[2*i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() > 0 || pend) && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk(name, (t < 200), 1);
  endtask

  initial forever begin
    @(posedge clk);
    ecnt++;
  end

  initial forever begin
    @(negedge clk);
    if (word_valid && clr_q.size() > 0) clr = clr_q.pop_front();
    else clr = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (pend) begin
      chk("locked", locked, cur.lk);
      chk("err_flag", err_flag, cur.fl);
      chk("err_count", err_count, cur.cnt);
      pend = 0;
    end
    if (rst_n && word_valid) begin
      if (!first_seen) begin
        chk("first_valid_latency", ecnt, 5);
        first_seen = 1;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("word_out", word_out, cur.word);
        pend = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      q1 = ~q1;
      q2 = q1;
      #1;
      chk("reset_outputs", {word_out, word_valid, locked, err_flag, err_count}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ecnt  = 0;

    // lock on 0xAA
    w(8'hAA, 0, 0, 0, 0); w(8'hAA, 0, 0, 0, 0); w(8'hAA, 0, 0, 0, 0);
    w(8'hAA, 0, 0, 0, 0); w(8'hAA, 1, 0, 0, 0);
    // single errors with recovery in between
    w(8'hAB, 1, 1, 1, 0); w(8'hAA, 1, 1, 1, 0);
    w(8'hAB, 1, 1, 2, 0); w(8'hAA, 1, 1, 2, 0);
    w(8'hAA, 1, 0, 0, 1);
    // relearn on 0x55 and relock
    w(8'h55, 1, 1, 1, 0); w(8'h55, 0, 1, 2, 0);
    w(8'h55, 0, 1, 2, 0); w(8'h55, 0, 1, 2, 0); w(8'h55, 0, 1, 2, 0);
    w(8'h55, 0, 1, 2, 0); w(8'h55, 1, 1, 2, 0);
    // clear wins over a same-cycle mismatch
    w(8'hAA, 1, 0, 0, 1); w(8'h55, 1, 0, 0, 0);
    // saturation with 2-bit counter
    w(8'hAA, 1, 1, 1, 0); w(8'h55, 1, 1, 1, 0);
    w(8'hAA, 1, 1, 2, 0); w(8'h55, 1, 1, 2, 0);
    w(8'hAA, 1, 1, 3, 0); w(8'h55, 1, 1, 3, 0);
    w(8'hAA, 1, 1, 3, 0); w(8'h55, 1, 1, 3, 0);
    w(8'hAA, 1, 1, 3, 0); w(8'h55, 1, 1, 3, 0);
    // relearn, then a mismatch while still checking restarts the match run
    w(8'h0F, 1, 1, 3, 0); w(8'h0F, 0, 1, 3, 0);
    w(8'h0F, 0, 1, 3, 0); w(8'h0F, 0, 1, 3, 0); w(8'h0F, 0, 1, 3, 0);
    w(8'hC3, 0, 1, 3, 0); w(8'hC3, 0, 1, 3, 0); w(8'hC3, 0, 1, 3, 0);
    w(8'hC3, 0, 1, 3, 0); w(8'hC3, 1, 1, 3, 0);
    drain("drain_main");

    // reset mid-word discards the partial word
    q1 = 1'b0; q2 = 1'b1;
    @(posedge clk); #1;
    q1 = 1'b1; q2 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("midword_reset_outputs", {word_out, word_valid, locked, err_flag, err_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    w(8'hAA, 0, 0, 0, 0);
    drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
